ula_arbiter: RTL and testbench

Shares one combinational ULA (32-bit ALU, func[2:0]: 000 add, 001 sub, 010 AND, 011 OR, 100 XNOR, 101 NOT A, 110 pass A, 111 NOT B; overflow flag pinV) between two requesters. Each requester has a valid/ready request channel and a valid/ready response channel. Arbitration between requesters is round-robin. The block drives the ULA operand and function inputs from registers and captures R/pinV into a result register. It sits between the ULA instance and the client blocks (sequencer, register-file writeback).

---
 rtl/ula_arbiter.sv | 116 +++++++++++
 tb/tb_ula_arbiter.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two valid/ready requesters.
// Accept -> resp_valid after 2 cycles; one op in flight; response held until the owner takes it.
module ula_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid0,
    input  logic             req_valid1,
    output logic             req_ready0,
    output logic             req_ready1,
    input  logic [WIDTH-1:0] req_A0,
    input  logic [WIDTH-1:0] req_A1,
    input  logic [WIDTH-1:0] req_B0,
    input  logic [WIDTH-1:0] req_B1,
    input  logic [2:0]       req_func0,
    input  logic [2:0]       req_func1,
    output logic             resp_valid0,
    output logic             resp_valid1,
    input  logic             resp_ready0,
    input  logic             resp_ready1,
    output logic [WIDTH-1:0] resp_R,
    output logic             resp_V,
    output logic [WIDTH-1:0] ula_A,
    output logic [WIDTH-1:0] ula_B,
    output logic [2:0]       ula_func,
    input  logic [WIDTH-1:0] ula_R,
    input  logic             ula_pinV,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             prio, owner;
    logic [WIDTH-1:0] op_A, op_B, res_R;
    logic [2:0]       op_func;
    logic             res_V;
    logic             grant0, grant1, resp_done;

    always_comb begin
        state_nxt   = state;
        grant0      = 1'b0;
        grant1      = 1'b0;
        resp_valid0 = 1'b0;
        resp_valid1 = 1'b0;
        resp_done   = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req_valid0 & (!req_valid1 | !prio);
                grant1 = req_valid1 & (!req_valid0 | prio);
                if (grant0 | grant1)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_valid0 = !owner;
                resp_valid1 = owner;
                resp_done   = owner ? resp_ready1 : resp_ready0;
                if (resp_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rst so nothing is offered while the block is held in reset.
    assign req_ready0 = grant0 & !rst;
    assign req_ready1 = grant1 & !rst;

    assign ula_A    = op_A;
    assign ula_B    = op_B;
    assign ula_func = op_func;
    assign resp_R   = res_R;
    assign resp_V   = res_V;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            owner   <= 1'b0;
            op_A    <= '0;
            op_B    <= '0;
            op_func <= '0;
            res_R   <= '0;
            res_V   <= 1'b0;
            cnt0    <= '0;
            cnt1    <= '0;
        end else begin
            state <= state_nxt;
            if (grant0 | grant1) begin
                op_A    <= grant1 ? req_A1 : req_A0;
                op_B    <= grant1 ? req_B1 : req_B0;
                op_func <= grant1 ? req_func1 : req_func0;
                owner   <= grant1;
                prio    <= !grant1;
            end
            if (state == EXEC) begin
                res_R <= ula_R;
                // Overflow only means something for add/sub.
                res_V <= ula_pinV & ((op_func == 3'b000) | (op_func == 3'b001));
            end
            if (resp_done) begin
                if (owner)
                    cnt1 <= cnt1 + CNT_W'(1);
                else
                    cnt0 <= cnt0 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: behavioural ULA model, directed scenarios and a randomized scoreboard run.
module tb_ula_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid0, req_valid1, req_ready0, req_ready1;
    logic [31:0] req_A0, req_A1, req_B0, req_B1;
    logic [2:0]  req_func0, req_func1;
    logic        resp_valid0, resp_valid1, resp_ready0, resp_ready1;
    logic [31:0] resp_R, ula_A, ula_B, ula_R;
    logic        resp_V, ula_pinV, busy;
    logic [2:0]  ula_func;
    logic [15:0] cnt0, cnt1;
    logic        force_v;
    logic        ula_v;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          owner;
        logic [31:0] r;
        logic        v;
    } exp_t;

    always #5 clk = ~clk;

    ula_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .req_A0(req_A0), .req_A1(req_A1), .req_B0(req_B0), .req_B1(req_B1),
        .req_func0(req_func0), .req_func1(req_func1),
        .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
        .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
        .resp_R(resp_R), .resp_V(resp_V),
        .ula_A(ula_A), .ula_B(ula_B), .ula_func(ula_func),
        .ula_R(ula_R), .ula_pinV(ula_pinV),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    // ULA stand-in; for logic ops pinV carries junk so the masking is exercised.
    always_comb begin
        ula_R = '0;
        ula_v = 1'b0;
        case (ula_func)
            3'b000: begin
                ula_R = ula_A + ula_B;
                ula_v = (ula_A[31] == ula_B[31]) && (ula_R[31] != ula_A[31]);
            end
            3'b001: begin
                ula_R = ula_A - ula_B;
                ula_v = (ula_A[31] != ula_B[31]) && (ula_R[31] != ula_A[31]);
            end
            3'b010: begin ula_R = ula_A & ula_B;    ula_v = ula_R[0]; end
            3'b011: begin ula_R = ula_A | ula_B;    ula_v = ula_R[0]; end
            3'b100: begin ula_R = ~(ula_A ^ ula_B); ula_v = ula_R[0]; end
            3'b101: begin ula_R = ~ula_A;           ula_v = ula_R[0]; end
            3'b110: begin ula_R = ula_A;            ula_v = ula_R[0]; end
            default: begin ula_R = ~ula_B;          ula_v = ula_R[0]; end
        endcase
        ula_pinV = ula_v | force_v;
    end

    // Expected {V,R}: overflow from exact signed arithmetic, zero for non-arithmetic ops.
    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      s  = 0;
        logic [31:0] r;
        logic        v  = 1'b0;
        case (f)
            3'd0: begin s = sa + sb; r = a + b; end
            3'd1: begin s = sa - sb; r = a - b; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~(a ^ b);
            3'd5: r = ~a;
            3'd6: r = a;
            default: r = ~b;
        endcase
        if (f == 3'd0 || f == 3'd1)
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {v, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f);
        if (k == 0) begin
            req_valid0 = 1'b1; req_A0 = a; req_B0 = b; req_func0 = f;
        end else begin
            req_valid1 = 1'b1; req_A1 = a; req_B1 = b; req_func1 = f;
        end
    endtask

    // Holds a request until accepted; returns one cycle after the accept edge (EXEC).
    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, output bit ok);
        ok = 1'b0;
        drive(k, a, b, f);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((k == 0 && req_ready0) || (k == 1 && req_ready1)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) step();
        if (k == 0) req_valid0 = 1'b0; else req_valid1 = 1'b0;
    endtask

    task automatic collect(input int k, output bit ok, output logic [31:0] r, output logic v);
        ok = 1'b0;
        r  = '0;
        v  = 1'b0;
        if (k == 0) resp_ready0 = 1'b1; else resp_ready1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((k == 0 && resp_valid0) || (k == 1 && resp_valid1)) begin
                ok = 1'b1;
                r  = resp_R;
                v  = resp_V;
                step();
                break;
            end
            step();
        end
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid0 = 1'b1;
        req_valid1 = 1'b1;
        #3;
        n_checks++;
        if ({req_ready0, req_ready1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b want 00", {req_ready0, req_ready1});
        end
        n_checks++;
        if ({resp_valid0, resp_valid1, busy, resp_V} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {resp_valid0, resp_valid1, busy, resp_V});
        end
        n_checks++;
        if ({ula_A, ula_B, ula_func, resp_R, cnt0, cnt1} !== '0) begin
            n_fail++; $display("FAIL reset_data: A=%h B=%h f=%0d R=%h c0=%0d c1=%0d want 0",
                               ula_A, ula_B, ula_func, resp_R, cnt0, cnt1);
        end
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        drive(0, 32'd5, 32'd7, 3'b000);
        #1;
        n_checks++;
        if (req_ready0 !== 1'b1) begin
            n_fail++; $display("FAIL add_ready0: got %b want 1", req_ready0);
        end
        step();
        req_valid0 = 1'b0;
        n_checks++;
        if ({resp_valid0, busy} !== 2'b01) begin
            n_fail++; $display("FAIL add_exec: resp_valid0/busy got %b want 01", {resp_valid0, busy});
        end
        step();
        n_checks++;
        if ({resp_valid0, resp_valid1, resp_R, resp_V} !== {2'b10, 32'd12, 1'b0}) begin
            n_fail++; $display("FAIL add_resp: v0=%b v1=%b R=%0d V=%b want 1 0 12 0",
                               resp_valid0, resp_valid1, resp_R, resp_V);
        end
        resp_ready0 = 1'b1;
        step();
        resp_ready0 = 1'b0;
        n_checks++;
        if ({cnt0, busy} !== {16'd1, 1'b0}) begin
            n_fail++; $display("FAIL add_cnt: cnt0=%0d busy=%b want 1 0", cnt0, busy);
        end
    endtask

    task automatic test_sub_ovf();
        bit ok;
        issue(1, 32'h8000_0000, 32'd1, 3'b001, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL sub_accept: timeout got 0 want 1"); end
        step();
        n_checks++;
        if ({resp_valid1, resp_valid0, resp_R, resp_V} !== {2'b10, 32'h7FFF_FFFF, 1'b1}) begin
            n_fail++; $display("FAIL sub_resp: v1=%b v0=%b R=%h V=%b want 1 0 7fffffff 1",
                               resp_valid1, resp_valid0, resp_R, resp_V);
        end
        resp_ready0 = 1'b1;
        step();
        n_checks++;
        if (resp_valid1 !== 1'b1) begin
            n_fail++; $display("FAIL sub_nonowner_ready: resp_valid1 got %b want 1", resp_valid1);
        end
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b1;
        step();
        resp_ready1 = 1'b0;
        n_checks++;
        if ({cnt1, cnt0} !== {16'd1, 16'd1}) begin
            n_fail++; $display("FAIL sub_cnt: cnt1=%0d cnt0=%0d want 1 1", cnt1, cnt0);
        end
    endtask

    task automatic test_flag_mask();
        bit ok;
        logic [31:0] r;
        logic v;
        force_v = 1'b1;
        issue(0, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b010, ok);
        collect(0, ok, r, v);
        force_v = 1'b0;
        n_checks++;
        if (!ok || r !== 32'h0F0F_0000 || v !== 1'b0) begin
            n_fail++; $display("FAIL flag_mask: ok=%b R=%h V=%b want 1 0f0f0000 0", ok, r, v);
        end
    endtask

    task automatic test_round_robin();
        exp_t q[$];
        exp_t e;
        int exp_own = 0, grants = 0, n_resp = 0, k;
        bit chg0 = 0, chg1 = 0;
        do_reset();
        drive(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
        drive(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
        resp_ready0 = 1'b1;
        resp_ready1 = 1'b1;
        #1;
        for (int cyc = 0; cyc < 60 && n_resp < 4; cyc++) begin
            if (chg0 || chg1) begin
                if (grants >= 4) begin
                    req_valid0 = 1'b0; req_valid1 = 1'b0;
                end else if (chg0) begin
                    drive(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
                end else begin
                    drive(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
                end
                chg0 = 0; chg1 = 0;
                #1;
            end
            n_checks++;
            if ((req_ready0 && req_ready1) || (busy && (req_ready0 || req_ready1))) begin
                n_fail++; $display("FAIL rr_grant_excl: rdy=%b%b busy=%b want no overlap",
                                   req_ready0, req_ready1, busy);
            end
            if (req_ready0 || req_ready1) begin
                k = req_ready1 ? 1 : 0;
                n_checks++;
                if (k != exp_own) begin
                    n_fail++; $display("FAIL rr_order: grant %0d got %0d want %0d", grants, k, exp_own);
                end
                e.owner = k;
                {e.v, e.r} = (k == 0) ? ref_op(req_A0, req_B0, req_func0)
                                      : ref_op(req_A1, req_B1, req_func1);
                q.push_back(e);
                exp_own = 1 - k;
                grants++;
                if (k == 0) chg0 = 1; else chg1 = 1;
            end
            if ((resp_valid0 || resp_valid1) && q.size() > 0) begin
                n_checks++;
                if (resp_valid1 != (q[0].owner == 1) || resp_R !== q[0].r || resp_V !== q[0].v) begin
                    n_fail++; $display("FAIL rr_resp: v1=%b R=%h V=%b want owner %0d R=%h V=%b",
                                       resp_valid1, resp_R, resp_V, q[0].owner, q[0].r, q[0].v);
                end
                void'(q.pop_front());
                n_resp++;
            end
            step();
        end
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b0;
        req_valid0  = 1'b0;
        req_valid1  = 1'b0;
        n_checks++;
        if (n_resp != 4 || cnt0 !== 16'd2 || cnt1 !== 16'd2) begin
            n_fail++; $display("FAIL rr_counts: resp=%0d cnt0=%0d cnt1=%0d want 4 2 2", n_resp, cnt0, cnt1);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] e0, e1;
        logic [31:0] r;
        logic v;
        bit ok;
        e0 = ref_op(32'h1234_5678, 32'h9ABC_DEF0, 3'b001);
        e1 = ref_op(32'h7FFF_FFFF, 32'h1, 3'b000);
        drive(0, 32'h1234_5678, 32'h9ABC_DEF0, 3'b001);
        drive(1, 32'h7FFF_FFFF, 32'h1, 3'b000);
        #1;
        n_checks++;
        if ({req_ready0, req_ready1} !== 2'b10) begin
            n_fail++; $display("FAIL bp_grant: rdy=%b%b want 10", req_ready0, req_ready1);
        end
        step();
        req_valid0 = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({resp_valid0, resp_valid1, req_ready1, resp_V, resp_R} !== {3'b100, e0}) begin
                n_fail++; $display("FAIL bp_hold: cyc %0d v0=%b v1=%b rdy1=%b V=%b R=%h want 1 0 0 %b %h",
                                   i, resp_valid0, resp_valid1, req_ready1, resp_V, resp_R, e0[32], e0[31:0]);
            end
            step();
        end
        resp_ready0 = 1'b1;
        step();
        resp_ready0 = 1'b0;
        #1;
        n_checks++;
        if (req_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL bp_next_accept: req_ready1 got %b want 1", req_ready1);
        end
        step();
        req_valid1 = 1'b0;
        collect(1, ok, r, v);
        n_checks++;
        if (!ok || {v, r} !== e1) begin
            n_fail++; $display("FAIL bp_resp1: ok=%b V=%b R=%h want 1 %b %h", ok, v, r, e1[32], e1[31:0]);
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        logic [31:0] r;
        logic v;
        int seen = 0;
        issue(0, 32'h0BAD_F00D, 32'h3, 3'b000, ok);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready0, req_ready1, resp_valid0, resp_valid1, busy, resp_V} !== 6'b0 ||
            {ula_A, ula_B, ula_func, resp_R, cnt0, cnt1} !== '0) begin
            n_fail++; $display("FAIL midop_reset: busy=%b A=%h R=%h c0=%0d c1=%0d want all 0",
                               busy, ula_A, resp_R, cnt0, cnt1);
        end
        #3;
        rst = 1'b0;
        resp_ready0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid0 || resp_valid1) seen++;
        end
        resp_ready0 = 1'b0;
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL midop_no_resp: responses got %0d want 0", seen);
        end
        issue(0, 32'hDEAD_BEEF, 32'h0, 3'b110, ok);
        collect(0, ok, r, v);
        n_checks++;
        if (!ok || r !== 32'hDEAD_BEEF || v !== 1'b0 || cnt0 !== 16'd1) begin
            n_fail++; $display("FAIL midop_after: ok=%b R=%h V=%b cnt0=%0d want 1 deadbeef 0 1", ok, r, v, cnt0);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int mprio = 0, mcnt0 = 0, mcnt1 = 0, k, exp_k;
        bit acc0 = 0, acc1 = 0;
        do_reset();
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (req_valid0 && !acc0) begin
                if ($urandom_range(0, 7) == 0) req_valid0 = 1'b0;
            end else if (cyc < 380 && $urandom_range(0, 1) == 1) begin
                drive(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
            end else begin
                req_valid0 = 1'b0;
            end
            if (req_valid1 && !acc1) begin
                if ($urandom_range(0, 7) == 0) req_valid1 = 1'b0;
            end else if (cyc < 380 && $urandom_range(0, 1) == 1) begin
                drive(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
            end else begin
                req_valid1 = 1'b0;
            end
            resp_ready0 = ($urandom_range(0, 3) != 0);
            resp_ready1 = ($urandom_range(0, 3) != 0);
            acc0 = 0;
            acc1 = 0;
            #1;
            n_checks++;
            if (cnt0 !== 16'(mcnt0) || cnt1 !== 16'(mcnt1)) begin
                n_fail++; $display("FAIL rnd_cnt: cyc %0d cnt0=%0d cnt1=%0d want %0d %0d",
                                   cyc, cnt0, cnt1, mcnt0, mcnt1);
            end
            if (req_ready0 || req_ready1) begin
                k = req_ready1 ? 1 : 0;
                exp_k = (req_valid0 && req_valid1) ? mprio : (req_valid1 ? 1 : 0);
                n_checks++;
                if (req_ready0 && req_ready1 || k != exp_k || q.size() != 0) begin
                    n_fail++; $display("FAIL rnd_grant: cyc %0d rdy=%b%b pend=%0d want grant %0d",
                                       cyc, req_ready0, req_ready1, q.size(), exp_k);
                end
                e.owner = k;
                {e.v, e.r} = (k == 0) ? ref_op(req_A0, req_B0, req_func0)
                                      : ref_op(req_A1, req_B1, req_func1);
                q.push_back(e);
                mprio = 1 - k;
                if (k == 0) acc0 = 1; else acc1 = 1;
            end
            if (resp_valid0 || resp_valid1) begin
                n_checks++;
                if (q.size() == 0 || (resp_valid0 && resp_valid1) || resp_valid1 != (q[0].owner == 1) ||
                    resp_R !== q[0].r || resp_V !== q[0].v) begin
                    n_fail++; $display("FAIL rnd_resp: cyc %0d v=%b%b R=%h V=%b pend=%0d",
                                       cyc, resp_valid0, resp_valid1, resp_R, resp_V, q.size());
                end
                if (q.size() > 0 && ((q[0].owner == 0 && resp_ready0) || (q[0].owner == 1 && resp_ready1))) begin
                    if (q[0].owner == 0) mcnt0 = (mcnt0 + 1) % 65536;
                    else                 mcnt1 = (mcnt1 + 1) % 65536;
                    void'(q.pop_front());
                end
            end
            step();
        end
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b0;
        n_checks++;
        if (q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rnd_drain: pending=%0d busy=%b want 0 0", q.size(), busy);
        end
    endtask

    initial begin
        rst = 1'b0;
        force_v = 1'b0;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_A0 = '0; req_A1 = '0; req_B0 = '0; req_B1 = '0;
        req_func0 = '0; req_func1 = '0;
        resp_ready0 = 1'b0; resp_ready1 = 1'b0;
        #2;
        test_reset();
        test_add();
        test_sub_ovf();
        test_flag_mask();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
